// File: rtl/debounce_pkg.sv
// Shared types and constants for the board-input debounce path.
// Holds the FSM state encoding and the saturating increment for the glitch counter.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } deb_state_t;

    localparam logic [7:0] GLITCH_MAX          = 8'hFF;
    localparam int         DEB_CYCLES_50M_10MS = 500_000;

    function automatic logic [7:0] glitch_sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == GLITCH_MAX) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for an asynchronous single-bit board input.
// Reusable for any other raw input that has to enter the clk50m domain.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    // Shift chain; only the first stage ever sees the asynchronous input.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a bouncing board input into a clean level.
// Also exposes a confirmation-in-progress flag and a saturating abort counter.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEB_CYCLES_50M_10MS,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       in_raw,
    output logic       debounced,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam deb_state_t       RST_STATE = RST_VAL ? S_HIGH : S_LOW;

    logic             sync_s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             busy_q, busy_d;
    logic [7:0]       glitch_q, glitch_d;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .d      (in_raw),
        .q      (sync_s)
    );

    // Next state: a level change must persist for the full count; sync is tested before the count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        deb_d    = deb_q;
        glitch_d = glitch_q;
        case (state_q)
            S_LOW: begin
                if (sync_s) begin
                    state_d = S_CHK_HIGH;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_LOW;
                end
            end
            S_CHK_HIGH: begin
                if (!sync_s) begin
                    state_d  = S_LOW;
                    cnt_d    = CNT_ZERO;
                    glitch_d = glitch_sat_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    deb_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sync_s) begin
                    state_d = S_CHK_LOW;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = S_HIGH;
                end
            end
            S_CHK_LOW: begin
                if (sync_s) begin
                    state_d  = S_HIGH;
                    cnt_d    = CNT_ZERO;
                    glitch_d = glitch_sat_inc(glitch_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    deb_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = CNT_ZERO;
                deb_d   = RST_VAL;
            end
        endcase
        busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= CNT_ZERO;
            deb_q    <= RST_VAL;
            busy_q   <= 1'b0;
            glitch_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    assign debounced  = deb_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed plus randomized bench for debounce_sync; two instances share in_raw
// and are checked every cycle against a run-length reference model.
module tb_debounce_sync;

    logic       clk50m = 1'b0;
    logic       rst_n;
    logic       in_raw;
    logic       deb0, busy0, deb1, busy1;
    logic [7:0] gl0, gl1;

    int ncmp = 0;
    int nerr = 0;

    // Reference model state: instance 0 = (2 stages, 4 cycles, reset 0), instance 1 = (3, 1, 1)
    int         sync_m   [2] = '{2, 3};
    int         debc_m   [2] = '{4, 1};
    logic       rstv_m   [2] = '{1'b0, 1'b1};
    logic [7:0] hist_m   [2];
    logic       deb_m    [2];
    int         streak_m [2];
    int         glitch_m [2];

    int rises, falls;
    logic prev_deb0;

    always #10 clk50m = ~clk50m;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RST_VAL(1'b0)) u_dut0 (
        .clk50m(clk50m), .rst_n(rst_n), .in_raw(in_raw),
        .debounced(deb0), .busy(busy0), .glitch_cnt(gl0));

    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RST_VAL(1'b1)) u_dut1 (
        .clk50m(clk50m), .rst_n(rst_n), .in_raw(in_raw),
        .debounced(deb1), .busy(busy1), .glitch_cnt(gl1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hist_m[i]   = {8{rstv_m[i]}};
            deb_m[i]    = rstv_m[i];
            streak_m[i] = 0;
            glitch_m[i] = 0;
        end
    endtask

    // streak = number of consecutive sync samples consumed that differ from the output level
    task automatic model_edge();
        logic s;
        for (int i = 0; i < 2; i++) begin
            s = hist_m[i][sync_m[i]-1];
            hist_m[i] = {hist_m[i][6:0], in_raw};
            if (s == deb_m[i]) begin
                if (streak_m[i] != 0 && glitch_m[i] < 255) glitch_m[i]++;
                streak_m[i] = 0;
            end else begin
                streak_m[i]++;
                if (streak_m[i] == debc_m[i] + 1) begin
                    deb_m[i]    = ~deb_m[i];
                    streak_m[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("deb0", deb0, deb_m[0]);
        check("busy0", busy0, streak_m[0] != 0);
        check("glitch0", gl0, glitch_m[0]);
        check("deb1", deb1, deb_m[1]);
        check("busy1", busy1, streak_m[1] != 0);
        check("glitch1", gl1, glitch_m[1]);
    endtask

    task automatic step(input logic v);
        @(negedge clk50m);
        in_raw = v;
        @(posedge clk50m);
        model_edge();
        #1;
        check_all();
        if (deb0 && !prev_deb0) rises++;
        if (!deb0 && prev_deb0) falls++;
        prev_deb0 = deb0;
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    // Edge index (1 = first edge sampling v) at which deb0 changes, and busy cycles before it
    task automatic measure(input logic v, input int n, output int lat, output int busy_n);
        logic start;
        start  = deb0;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= n; i++) begin
            step(v);
            if (lat == 0 && deb0 !== start) lat = i;
            if (lat == 0 && busy0 === 1'b1) busy_n++;
        end
    endtask

    task automatic release_reset();
        @(posedge clk50m);
        #2;
        model_reset();
        rst_n = 1'b1;
        prev_deb0 = deb0;
    endtask

    initial begin
        int lat, bn, base;
        logic seen_high;

        rises = 0;
        falls = 0;
        rst_n  = 1'b1;
        in_raw = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_deb0", deb0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_glitch0", gl0, 8'h00);
        check("rst_deb1", deb1, 1'b1);
        check("rst_busy1", busy1, 1'b0);

        release_reset();
        measure(1'b1, 12, lat, bn);
        check("release_latency", lat, 7);
        check("release_busy_cycles", bn, 4);

        run(1'b0, 12);
        rises = 0;
        falls = 0;
        measure(1'b1, 20, lat, bn);
        check("press_latency", lat, 7);
        measure(1'b0, 12, lat, bn);
        check("release_fall_latency", lat, 7);
        check("edge_rise_count", rises, 1);
        check("edge_fall_count", falls, 1);
        check("clean_glitch", gl0, 8'h00);

        base = gl0;
        seen_high = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step((i % 4) < 2);
            if (deb0 !== 1'b0) seen_high = 1'b1;
        end
        check("burst_no_pulse", seen_high, 1'b0);
        measure(1'b1, 12, lat, bn);
        check("burst_glitch", gl0, base + 2);
        check("burst_settle_latency", lat, 7);

        run(1'b0, 12);
        base = gl0;
        run(1'b1, 3);
        run(1'b0, 8);
        check("late_glitch_count", gl0, base + 1);
        check("late_glitch_deb", deb0, 1'b0);
        check("late_glitch_busy", busy0, 1'b0);
        run(1'b1, 4);
        run(1'b0, 8);
        check("last_cycle_abort_count", gl0, base + 2);
        check("last_cycle_abort_deb", deb0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            run(1'($urandom_range(0, 1)), $urandom_range(1, 7));
        end

        run(1'b0, 12);
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            step(1'b0);
        end
        check("saturate0", gl0, 8'hFF);
        check("saturate1", gl1, 8'hFF);
        run(1'b1, 1);
        run(1'b0, 3);
        check("saturate_no_wrap", gl0, 8'hFF);

        run(1'b0, 12);
        run(1'b1, 5);
        check("midcheck_busy_before", busy0, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_busy0", busy0, 1'b0);
        check("async_rst_deb0", deb0, 1'b0);
        check("async_rst_glitch0", gl0, 8'h00);
        check("async_rst_deb1", deb1, 1'b1);
        release_reset();
        measure(1'b1, 12, lat, bn);
        check("post_rst_latency", lat, 7);
        check("post_rst_busy_cycles", bn, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Upstream conditioning stage for edge_detect.
- Takes a raw, asynchronous, bouncing board input (push button / switch), synchronises it into the clk50m domain and removes bounce.
- Drives a single clean level `debounced`, which feeds edge_detect's `in` directly.
- Also reports when a confirmation is in progress and how many bounce aborts have occurred, for debug LEDs / seven-segment display.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops (legal range 2..4).
- DEBOUNCE_CYCLES, 500_000, clock cycles the synchronised input must stay stable before the output follows (10 ms at 50 MHz; minimum 1).
- RST_VAL, 1'b0, value of the synchroniser flops and `debounced` during reset.

Ports:
- clk50m  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_raw  input  1  raw asynchronous board input.
- debounced  output  1  clean registered level; connects to edge_detect `in`.
- busy  output  1  high while the block is confirming a candidate change.
- glitch_cnt  output  8  saturating count of aborted confirmations.

Behaviour:
- One clock (clk50m, rising edge). Reset is asynchronous and active-low (rst_n).
- All registers clear immediately on rst_n=0, independent of the clock.
- Reset values:
  - synchroniser flops = RST_VAL
  - debounced = RST_VAL
  - busy = 0
  - glitch_cnt = 0
  - counter = 0
  - FSM = S_LOW if RST_VAL=0, else S_HIGH
- Synchroniser: SYNC_STAGES-deep shift chain on in_raw. `sync` is the last stage. No other logic reads in_raw.
- FSM states: S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW.
  - S_LOW: sync=1 -> S_CHK_HIGH, cnt<=0. Otherwise stay.
  - S_CHK_HIGH:
    - sync=0 -> S_LOW, cnt<=0, glitch_cnt++ (saturating).
    - else if cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, debounced<=1.
    - else cnt++.
  - S_HIGH / S_CHK_LOW: mirror of the above with polarity inverted; debounced<=0 on confirmation.
- busy = 1 exactly while in S_CHK_HIGH or S_CHK_LOW. It is registered (decoded from the state register).
- debounced changes only on the confirming transition. A bounce never produces an output pulse.
- Latency: after in_raw settles before rising edge k, debounced changes at edge k+SYNC_STAGES+DEBOUNCE_CYCLES. Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives 6 edges after the sampling edge, i.e. 7 edges counting it.
- Counter width: $clog2(DEBOUNCE_CYCLES). Minimum 1 bit. No wrap: the counter never exceeds DEBOUNCE_CYCLES-1.
- glitch_cnt saturates at 8'hFF. It is cleared only by reset.
- Boundary conditions:
  - in_raw toggles on the very cycle cnt==DEBOUNCE_CYCLES-1: sync is checked first, so the result is an abort (no confirm) plus a glitch count.
  - DEBOUNCE_CYCLES=1: confirm on the first cycle spent in the CHK state.
  - in_raw equal to debounced while in a stable state: no activity; busy stays 0.
  - Reset mid-check: FSM returns to the reset state, partial count discarded, no output change other than forcing RST_VAL.
  - Reset release: in_raw already differs from RST_VAL -> normal confirmation sequence starts once sync reflects it.

Decomposition:
- Package debounce_pkg holds:
  - typedef enum logic [1:0] deb_state_t {S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW}
  - localparam GLITCH_MAX = 8'hFF
  - localparam DEB_CYCLES_50M_10MS = 500_000
- Sub-module sync_ff:
  - Parameters: STAGES, RST_VAL.
  - Ports: clk50m, rst_n, d, q.
  - Reused later for other asynchronous board inputs.
- The FSM, counter and glitch counter stay in debounce_sync.

Test Plan:
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless stated. Inputs change at negedge clk50m.
- Reset check: rst_n=0, in_raw=1, RST_VAL=0 -> debounced=0, busy=0, glitch_cnt=0, with no clock edge required. Release rst_n, hold in_raw=1 -> debounced=1 exactly 7 rising edges after the first edge that samples in_raw=1; busy high for 4 cycles before that.
- Clean press/release: in_raw 0->1, hold 20 cycles, then 1->0 -> debounced rises at edge 7 and falls 7 edges after the release is sampled; glitch_cnt=0. A connected edge_detect gives exactly one risingedge and one fallingedge.
- Bounce burst: in_raw toggles 1,0,1,0 every 2 cycles, then stays 1 -> debounced stays 0 throughout the burst; each abort increments glitch_cnt (expect 2); debounced=1 only after 4 stable cycles.
- Late glitch: in_raw=1 for exactly 3 sampled cycles, then 0 -> no confirmation, debounced=0, glitch_cnt=1, busy returns to 0.
- Saturation: 300 aborted checks -> glitch_cnt=8'hFF, no wrap to 0.
- Asynchronous reset mid-check: assert rst_n=0 while busy=1 and cnt=2, between clock edges -> busy=0, debounced=RST_VAL immediately. After release with in_raw still 1, the full 7-edge latency applies again.
